slave_port_arbiter: RTL

- Shares one slave port of the 2-master / 2-slave interconnect between master 0 and master 1.
- Accepts one transaction at a time and arbitrates round-robin.
- Drives the slave request, forwards the slave ack to the owning master, and routes read data back to the owning master.
- Exports per-master 2-bit status using the interconnect encoding: NO_REQ=0, WAIT=1, W_ACK=2, W_DATA=3. This status is what the per-master rdata routing logic consumes.

---
 rtl/slave_port_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter that shares one slave port between two masters, one
// transaction at a time, and routes ack and read data back to the owner.
module slave_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              master0_req,
    input  logic [ADDR_W-1:0] master0_addr,
    input  logic              master0_cmd,
    input  logic [DATA_W-1:0] master0_wdata,
    output logic              master0_ack,
    output logic [DATA_W-1:0] master0_rdata,
    output logic              master0_resp,
    input  logic              master1_req,
    input  logic [ADDR_W-1:0] master1_addr,
    input  logic              master1_cmd,
    input  logic [DATA_W-1:0] master1_wdata,
    output logic              master1_ack,
    output logic [DATA_W-1:0] master1_rdata,
    output logic              master1_resp,
    output logic              slave_req,
    output logic [ADDR_W-1:0] slave_addr,
    output logic              slave_cmd,
    output logic [DATA_W-1:0] slave_wdata,
    input  logic              slave_ack,
    input  logic [DATA_W-1:0] slave_rdata,
    input  logic              slave_resp,
    output logic [1:0]        stat0,
    output logic [1:0]        stat1
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_W_ACK  = 2'd1,
        S_W_DATA = 2'd2
    } state_t;

    localparam logic [1:0] ST_NO_REQ = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_W_ACK  = 2'd2;
    localparam logic [1:0] ST_W_DATA = 2'd3;

    state_t r_state;
    state_t w_next_state;
    logic   r_grant;
    logic   w_next_grant;
    logic   r_lp;
    logic   w_next_lp;

    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_cmd;
    logic [DATA_W-1:0] w_sel_wdata;

    // Owner status wins; otherwise a pending request reads as WAIT.
    function automatic logic [1:0] master_stat(input state_t st, input logic owner,
                                               input logic req);
        logic [1:0] s;
        if (owner && (st == S_W_ACK)) begin
            s = ST_W_ACK;
        end else if (owner && (st == S_W_DATA)) begin
            s = ST_W_DATA;
        end else if (req) begin
            s = ST_WAIT;
        end else begin
            s = ST_NO_REQ;
        end
        return s;
    endfunction

    assign w_sel_addr  = r_grant ? master1_addr  : master0_addr;
    assign w_sel_cmd   = r_grant ? master1_cmd   : master0_cmd;
    assign w_sel_wdata = r_grant ? master1_wdata : master0_wdata;

    // State, grant and last-grant pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_lp    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_lp    <= w_next_lp;
        end
    end

    // Next-state logic; lp only moves to the master that just completed.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_lp    = r_lp;
        case (r_state)
            S_IDLE: begin
                if (master0_req && master1_req) begin
                    w_next_grant = ~r_lp;
                    w_next_state = S_W_ACK;
                end else if (master0_req) begin
                    w_next_grant = 1'b0;
                    w_next_state = S_W_ACK;
                end else if (master1_req) begin
                    w_next_grant = 1'b1;
                    w_next_state = S_W_ACK;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_W_ACK: begin
                if (slave_ack && w_sel_cmd) begin
                    w_next_state = S_IDLE;
                    w_next_lp    = r_grant;
                end else if (slave_ack) begin
                    w_next_state = S_W_DATA;
                end else begin
                    w_next_state = S_W_ACK;
                end
            end
            S_W_DATA: begin
                if (slave_resp) begin
                    w_next_state = S_IDLE;
                    w_next_lp    = r_grant;
                end else begin
                    w_next_state = S_W_DATA;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Slave-side mux, ack/rdata routing and per-master status.
    always_comb begin
        slave_req     = 1'b0;
        slave_addr    = {ADDR_W{1'b0}};
        slave_cmd     = 1'b0;
        slave_wdata   = {DATA_W{1'b0}};
        master0_ack   = 1'b0;
        master1_ack   = 1'b0;
        master0_resp  = 1'b0;
        master1_resp  = 1'b0;
        master0_rdata = {DATA_W{1'b0}};
        master1_rdata = {DATA_W{1'b0}};
        case (r_state)
            S_W_ACK: begin
                slave_req   = 1'b1;
                slave_addr  = w_sel_addr;
                slave_cmd   = w_sel_cmd;
                slave_wdata = w_sel_wdata;
                master0_ack = slave_ack & ~r_grant;
                master1_ack = slave_ack & r_grant;
            end
            S_W_DATA: begin
                if (slave_resp && !r_grant) begin
                    master0_resp  = 1'b1;
                    master0_rdata = slave_rdata;
                end else if (slave_resp && r_grant) begin
                    master1_resp  = 1'b1;
                    master1_rdata = slave_rdata;
                end else begin
                    master0_resp = 1'b0;
                    master1_resp = 1'b0;
                end
            end
            default: begin
                slave_req = 1'b0;
            end
        endcase
        stat0 = master_stat(r_state, ~r_grant, master0_req);
        stat1 = master_stat(r_state, r_grant, master1_req);
    end

endmodule
